// File: rtl/jtag_dr_bank_if.sv
// TAP-side signals of the data-register bank: serial data, DR control strobes,
// decoded instruction selects and the retimed serial output.
interface jtag_dr_bank_if;
  logic TDI;
  logic CAPTUREDR;
  logic SHIFTDR;
  logic UPDATEDR;
  logic IDCODE_SELECT;
  logic BYPASS_SELECT;
  logic SAMPLE_SELECT;
  logic EXTEST_SELECT;
  logic INTEST_SELECT;
  logic USERCODE_SELECT;
  logic RUNBIST_SELECT;
  logic TDO;

  // TAP controller / instruction decoder side
  modport master (
    output TDI, CAPTUREDR, SHIFTDR, UPDATEDR,
    output IDCODE_SELECT, BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT,
    output INTEST_SELECT, USERCODE_SELECT, RUNBIST_SELECT,
    input  TDO
  );

  // Data-register bank side
  modport slave (
    input  TDI, CAPTUREDR, SHIFTDR, UPDATEDR,
    input  IDCODE_SELECT, BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT,
    input  INTEST_SELECT, USERCODE_SELECT, RUNBIST_SELECT,
    output TDO
  );
endinterface

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE, USERCODE, RUNBIST status and a
// boundary-scan register with update stage, shift-length checking and negedge TDO.
module jtag_dr_bank #(
  parameter int              ID_W     = 8,
  parameter logic [ID_W-1:0] ID_VALUE = 8'hA1,
  parameter int              UC_W     = 8,
  parameter logic [UC_W-1:0] UC_RESET = 8'h01,
  parameter int              IO_N     = 4,
  parameter int              CL_N     = 4,
  parameter int              BIST_W   = 16,
  parameter int              CNT_W    = 8
) (
  input  logic              TCK,
  input  logic              TRST,
  jtag_dr_bank_if.slave     tap,
  input  logic [IO_N-1:0]   PIN_IN,
  input  logic [CL_N-1:0]   CORE_IN,
  input  logic [IO_N-1:0]   PIN_FUNC,
  input  logic [CL_N-1:0]   CORE_FUNC,
  input  logic [BIST_W-1:0] BIST_DATA,
  output logic [IO_N-1:0]   PIN_OUT,
  output logic [CL_N-1:0]   CORE_OUT,
  output logic [UC_W-1:0]   UR_OUT,
  output logic              LEN_ERR
);

  localparam int BSR_W = IO_N + CL_N + 2;
  localparam int UPD_W = IO_N + CL_N;

  localparam logic [CNT_W-1:0] LEN_USER = CNT_W'(UC_W);
  localparam logic [CNT_W-1:0] LEN_BSR  = CNT_W'(BSR_W);

  typedef enum logic [2:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USERCODE,
    DR_RUNBIST,
    DR_EXTEST,
    DR_INTEST,
    DR_SAMPLE
  } dr_sel_e;

  dr_sel_e            dr_sel;
  logic               bypass_sr;
  logic [ID_W-1:0]    id_sr;
  logic [UC_W-1:0]    uc_sr;
  logic [BIST_W-1:0]  bist_sr;
  logic [BSR_W-1:0]   bsr_sr;
  logic [BSR_W-1:0]   bsr_cap;
  // Update stage holds {pin field, core field}; the marker bits never leave the chain.
  logic [UPD_W-1:0]   bsr_upd;
  logic [CNT_W-1:0]   shift_cnt;
  logic               tdo_bit;
  logic               tdo_q;

  // Fixed instruction priority; no select at all falls through to BYPASS.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dr_sel = DR_BYPASS;
    if      (tap.IDCODE_SELECT)   dr_sel = DR_IDCODE;
    else if (tap.USERCODE_SELECT) dr_sel = DR_USERCODE;
    else if (tap.RUNBIST_SELECT)  dr_sel = DR_RUNBIST;
    else if (tap.EXTEST_SELECT)   dr_sel = DR_EXTEST;
    else if (tap.INTEST_SELECT)   dr_sel = DR_INTEST;
    else if (tap.SAMPLE_SELECT)   dr_sel = DR_SAMPLE;
  end

  // INTEST recirculates the pin field already sitting in the update stage.
  always_comb begin
    bsr_cap = {PIN_IN, CORE_IN, 2'b01};
    if (dr_sel == DR_INTEST) begin
      bsr_cap = {bsr_upd[CL_N +: IO_N], CORE_IN, 2'b01};
    end
  end

  // NOTE: TRST is sampled synchronously, and all state uses non-blocking assignments.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      bypass_sr <= 1'b0;
      id_sr     <= '0;
      uc_sr     <= '0;
      bist_sr   <= '0;
      bsr_sr    <= '0;
      bsr_upd   <= '0;
      UR_OUT    <= UC_RESET;
      shift_cnt <= '0;
      LEN_ERR   <= 1'b0;
    end else if (tap.CAPTUREDR) begin
      shift_cnt <= '0;
      if (tap.IDCODE_SELECT) LEN_ERR <= 1'b0;
      unique case (dr_sel)
        DR_IDCODE:   id_sr     <= ID_VALUE;
        DR_USERCODE: uc_sr     <= UR_OUT;
        DR_RUNBIST:  bist_sr   <= BIST_DATA;
        DR_EXTEST,
        DR_INTEST,
        DR_SAMPLE:   bsr_sr    <= bsr_cap;
        default:     bypass_sr <= 1'b0;
      endcase
    end else if (tap.SHIFTDR) begin
      if (shift_cnt != '1) shift_cnt <= shift_cnt + 1'b1;
      unique case (dr_sel)
        DR_IDCODE:   id_sr     <= {tap.TDI, id_sr[ID_W-1:1]};
        DR_USERCODE: uc_sr     <= {tap.TDI, uc_sr[UC_W-1:1]};
        DR_RUNBIST:  bist_sr   <= {tap.TDI, bist_sr[BIST_W-1:1]};
        DR_EXTEST,
        DR_INTEST,
        DR_SAMPLE:   bsr_sr    <= {tap.TDI, bsr_sr[BSR_W-1:1]};
        default:     bypass_sr <= tap.TDI;
      endcase
    end else if (tap.UPDATEDR) begin
      // A short or long shift leaves the target untouched and raises the sticky flag.
      unique case (dr_sel)
        DR_USERCODE: begin
          if (shift_cnt == LEN_USER) UR_OUT  <= uc_sr;
          else                       LEN_ERR <= 1'b1;
        end
        DR_EXTEST,
        DR_INTEST,
        DR_SAMPLE: begin
          if (shift_cnt == LEN_BSR) bsr_upd <= bsr_sr[BSR_W-1:2];
          else                      LEN_ERR <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo_bit = bypass_sr;
    unique case (dr_sel)
      DR_IDCODE:   tdo_bit = id_sr[0];
      DR_USERCODE: tdo_bit = uc_sr[0];
      DR_RUNBIST:  tdo_bit = bist_sr[0];
      DR_EXTEST,
      DR_INTEST,
      DR_SAMPLE:   tdo_bit = bsr_sr[0];
      default:     tdo_bit = bypass_sr;
    endcase
  end

  // Retiming on the falling edge gives the far end a half cycle of setup.
  always_ff @(negedge TCK) begin
    if (TRST) begin
      tdo_q <= 1'b0;
    end else if (tap.SHIFTDR) begin
      tdo_q <= tdo_bit;
    end
  end

  assign tap.TDO = tdo_q;

  // Drives follow the raw selects, so changing instruction switches them at once.
  assign PIN_OUT  = tap.EXTEST_SELECT ? bsr_upd[CL_N +: IO_N] : PIN_FUNC;
  assign CORE_OUT = tap.INTEST_SELECT ? bsr_upd[0 +: CL_N]    : CORE_FUNC;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed bench for jtag_dr_bank: walks each data register through
// capture/shift/update and compares against hand-computed values.
module tb_jtag_dr_bank;

  logic        TCK;
  logic        TRST;
  logic [3:0]  PIN_IN;
  logic [3:0]  CORE_IN;
  logic [3:0]  PIN_FUNC;
  logic [3:0]  CORE_FUNC;
  logic [15:0] BIST_DATA;
  logic [3:0]  PIN_OUT;
  logic [3:0]  CORE_OUT;
  logic [7:0]  UR_OUT;
  logic        LEN_ERR;

  int n_checks = 0;
  int n_errors = 0;

  jtag_dr_bank_if tap ();

  jtag_dr_bank dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .tap       (tap),
    .PIN_IN    (PIN_IN),
    .CORE_IN   (CORE_IN),
    .PIN_FUNC  (PIN_FUNC),
    .CORE_FUNC (CORE_FUNC),
    .BIST_DATA (BIST_DATA),
    .PIN_OUT   (PIN_OUT),
    .CORE_OUT  (CORE_OUT),
    .UR_OUT    (UR_OUT),
    .LEN_ERR   (LEN_ERR)
  );

  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One TCK cycle: TDO sampled just after the falling edge, inputs settle after the rising edge.
  task automatic tick(output logic tdo_s);
    @(negedge TCK);
    #1 tdo_s = tap.TDO;
    @(posedge TCK);
    #1;
  endtask

  task automatic clear_sel();
    tap.IDCODE_SELECT   = 1'b0;
    tap.BYPASS_SELECT   = 1'b0;
    tap.SAMPLE_SELECT   = 1'b0;
    tap.EXTEST_SELECT   = 1'b0;
    tap.INTEST_SELECT   = 1'b0;
    tap.USERCODE_SELECT = 1'b0;
    tap.RUNBIST_SELECT  = 1'b0;
  endtask

  task automatic capture();
    logic d;
    tap.CAPTUREDR = 1'b1;
    tick(d);
    tap.CAPTUREDR = 1'b0;
  endtask

  task automatic shift(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic b;
    dout = '0;
    tap.SHIFTDR = 1'b1;
    for (int i = 0; i < n; i++) begin
      tap.TDI = din[i];
      tick(b);
      dout[i] = b;
    end
    tap.SHIFTDR = 1'b0;
    tap.TDI     = 1'b0;
  endtask

  task automatic update();
    logic d;
    tap.UPDATEDR = 1'b1;
    tick(d);
    tap.UPDATEDR = 1'b0;
  endtask

  initial begin
    logic [31:0] dout;
    logic        d;

    TRST          = 1'b1;
    tap.TDI       = 1'b0;
    tap.CAPTUREDR = 1'b0;
    tap.SHIFTDR   = 1'b0;
    tap.UPDATEDR  = 1'b0;
    clear_sel();
    PIN_IN    = 4'h0;
    CORE_IN   = 4'h0;
    PIN_FUNC  = 4'h5;
    CORE_FUNC = 4'hC;
    BIST_DATA = 16'h0000;
    tick(d);
    tick(d);
    TRST = 1'b0;

    // Reset state
    check("rst_tdo",     tap.TDO, 1'b0);
    check("rst_ur",      UR_OUT,  8'h01);
    check("rst_len_err", LEN_ERR, 1'b0);
    check("rst_pin_func", PIN_OUT, 4'h5);
    tap.EXTEST_SELECT = 1'b1;
    tap.INTEST_SELECT = 1'b1;
    #1;
    check("rst_pin_upd",  PIN_OUT,  4'h0);
    check("rst_core_upd", CORE_OUT, 4'h0);
    clear_sel();

    // BYPASS (no select): TDI 1,0,1,1 -> TDO 0,1,0,1
    capture();
    shift(32'hD, 4, dout);
    check("bypass_stream", dout, 32'hA);
    update();
    check("bypass_no_flag", LEN_ERR, 1'b0);

    // USERCODE good update, then short shift
    tap.USERCODE_SELECT = 1'b1;
    capture();
    shift(32'h5C, 8, dout);
    check("user_capture_stream", dout, 32'h01);
    update();
    check("user_update", UR_OUT, 8'h5C);
    check("user_len_ok", LEN_ERR, 1'b0);
    capture();
    shift(32'h33, 7, dout);
    update();
    check("user_short_hold", UR_OUT, 8'h5C);
    check("user_short_flag", LEN_ERR, 1'b1);
    clear_sel();

    // IDCODE: capture clears the sticky flag
    tap.IDCODE_SELECT = 1'b1;
    capture();
    check("id_clears_flag", LEN_ERR, 1'b0);
    shift(32'h0, 8, dout);
    check("id_stream", dout, 32'hA1);
    clear_sel();

    // SAMPLE preload {pin A, core 3, 01}
    tap.SAMPLE_SELECT = 1'b1;
    capture();
    shift(32'h28D, 10, dout);
    update();
    check("sample_len_ok", LEN_ERR, 1'b0);
    check("sample_pin_func", PIN_OUT, 4'h5);
    clear_sel();
    tap.EXTEST_SELECT = 1'b1;
    #1;
    check("extest_pin_drive", PIN_OUT,  4'hA);
    check("extest_core_func", CORE_OUT, 4'hC);
    clear_sel();
    #1;
    check("pin_func_again", PIN_OUT, 4'h5);
    tap.INTEST_SELECT = 1'b1;
    #1;
    check("intest_core_drive", CORE_OUT, 4'h3);
    clear_sel();

    // EXTEST capture {6, 9, 01}
    tap.EXTEST_SELECT = 1'b1;
    PIN_IN  = 4'h6;
    CORE_IN = 4'h9;
    capture();
    shift(32'h0, 10, dout);
    check("extest_capture", dout, 32'h1A5);
    clear_sel();

    // INTEST capture recirculates update pin field: {A, 9, 01}
    tap.INTEST_SELECT = 1'b1;
    capture();
    shift(32'h0, 10, dout);
    check("intest_capture", dout, 32'h2A5);
    clear_sel();

    // RUNBIST outranks EXTEST; its update touches nothing
    tap.RUNBIST_SELECT = 1'b1;
    tap.EXTEST_SELECT  = 1'b1;
    BIST_DATA = 16'hBEEF;
    capture();
    shift(32'h0, 16, dout);
    check("bist_stream", dout, 32'hBEEF);
    update();
    check("bist_ur_hold",  UR_OUT,  8'h5C);
    check("bist_pin_hold", PIN_OUT, 4'hA);
    check("bist_no_flag",  LEN_ERR, 1'b0);
    clear_sel();

    // All selects high, capture and shift together: IDCODE capture wins
    tap.IDCODE_SELECT   = 1'b1;
    tap.BYPASS_SELECT   = 1'b1;
    tap.SAMPLE_SELECT   = 1'b1;
    tap.EXTEST_SELECT   = 1'b1;
    tap.INTEST_SELECT   = 1'b1;
    tap.USERCODE_SELECT = 1'b1;
    tap.RUNBIST_SELECT  = 1'b1;
    tap.CAPTUREDR = 1'b1;
    tap.SHIFTDR   = 1'b1;
    tap.TDI       = 1'b1;
    tick(d);
    tap.CAPTUREDR = 1'b0;
    tap.SHIFTDR   = 1'b0;
    tap.TDI       = 1'b0;
    shift(32'h0, 8, dout);
    check("prio_capture_over_shift", dout, 32'hA1);
    check("prio_ur_hold", UR_OUT, 8'h5C);
    clear_sel();

    // Reset in the middle of a USERCODE shift
    tap.USERCODE_SELECT = 1'b1;
    capture();
    shift(32'h0, 5, dout);
    check("mid_shift_stream", dout, 32'h1C);
    tap.SHIFTDR = 1'b1;
    TRST = 1'b1;
    tick(d);
    TRST = 1'b0;
    tap.SHIFTDR = 1'b0;
    check("mid_rst_ur",  UR_OUT,  8'h01);
    check("mid_rst_tdo", tap.TDO, 1'b0);
    update();
    check("mid_rst_no_update", UR_OUT,  8'h01);
    check("mid_rst_flag",      LEN_ERR, 1'b1);
    clear_sel();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
